// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Op encodings, FSM state type and default width for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One shift-add multiply or restoring-divide iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              is_div,
    input  logic [2*XLEN:0]   acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN:0]   acc_out,
    output logic              q_bit
);

    // Multiply: acc = {0, hi, lo}, multiplier bits consumed from lo[0].
    // Divide:   acc = {rem[32:0], dividend/quotient[31:0]}.
    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_divisor;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    always_comb begin
        w_sum     = {acc_in[2*XLEN], acc_in[2*XLEN-1:XLEN]}
                  + (acc_in[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        w_shifted = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        w_divisor = {1'b0, operand};
        w_ge      = (w_shifted >= w_divisor);
        w_diff    = w_shifted - w_divisor;
        q_bit     = is_div & w_ge;
        if (is_div) begin
            // Quotient bit slot left at zero; the caller merges q_bit in.
            acc_out = {(w_ge ? w_diff : w_shifted), acc_in[XLEN-2:0], 1'b0};
        end else begin
            acc_out = {1'b0, w_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative unsigned MUL/MULHU/DIVU/REMU with start/busy/done.
//               Optional macro MULDIV_EARLY_OUT_EN skips CALC for zero operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rc_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] ry,
    output logic [4:0]      rc,
    output logic            load_enable
);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN:0]   r_acc;
    logic [XLEN-1:0]   r_ry;
    logic [4:0]        r_rc;
    logic [2*XLEN:0]   w_acc_next;
    logic [2*XLEN:0]   w_acc_step;
    logic              w_q_bit;
    logic              w_last;
    logic              w_early;

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0]   w_early_ry;
    assign w_early    = (b == '0) || (!op[1] && (a == '0));
    assign w_early_ry = op[1] ? (op[0] ? a : {XLEN{1'b1}}) : {XLEN{1'b0}};
`else
    assign w_early    = 1'b0;
`endif

    muldiv_step #(
        .XLEN    (XLEN)
    ) u_step (
        .is_div  (r_op[1]),
        .acc_in  (r_acc),
        .operand (r_opnd),
        .acc_out (w_acc_next),
        .q_bit   (w_q_bit)
    );

    assign w_acc_step = w_acc_next | {{(2*XLEN){1'b0}}, w_q_bit};
    assign w_last     = (r_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_early ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_op   <= OP_MUL;
            r_opnd <= '0;
            r_acc  <= '0;
            r_ry   <= '0;
            r_rc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_rc   <= rc_in;
                        r_cnt  <= '0;
                        // Divide shifts the dividend through acc; multiply shifts the multiplier.
                        r_opnd <= op[1] ? b : a;
                        r_acc  <= {{(XLEN+1){1'b0}}, (op[1] ? a : b)};
`ifdef MULDIV_EARLY_OUT_EN
                        if (w_early) begin
                            r_ry <= w_early_ry;
                        end
`endif
                    end
                end
                CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // op[0] selects the upper half: MULHU product high or REMU remainder.
                        r_ry <= r_op[0] ? w_acc_step[2*XLEN-1:XLEN] : w_acc_step[XLEN-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ry          = r_ry;
    assign rc          = r_rc;
    assign load_enable = done;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rc_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] ry;
    logic [4:0]  rc;
    logic        load_enable;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .rc_in       (rc_in),
        .busy        (busy),
        .done        (done),
        .ry          (ry),
        .rc          (rc),
        .load_enable (load_enable)
    );

    always #5 clk = ~clk;

    // Issues one op and waits (bounded) for done; lat = -1 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] d, output int lat, output int bc,
                          output logic [31:0] r, output logic [4:0] c, output logic le);
        lat = -1; bc = 0; r = '0; c = '0; le = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; rc_in = d;
        @(negedge clk);
        start = 1'b0; a = 32'hA5A5_A5A5; b = 32'h5A5A_5A5A; rc_in = 5'd31;
        for (int i = 1; i <= 100; i++) begin
            if (busy) bc++;
            if (done) begin
                lat = i; r = ry; c = rc; le = load_enable;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd4;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_tests++; if (load_enable !== 1'b0) begin n_fail++; $display("FAIL reset_le got %0b want 0", load_enable); end
        n_tests++; if (ry !== 32'd0) begin n_fail++; $display("FAIL reset_ry got %h want 0", ry); end
        n_tests++; if (rc !== 5'd0) begin n_fail++; $display("FAIL reset_rc got %0d want 0", rc); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_mul;
        int lat, bc; logic [31:0] r; logic [4:0] c; logic le;
        run_op(OP_MUL, 32'd7, 32'd10, 5'd3, lat, bc, r, c, le);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency got %0d want 33", lat); end
        n_tests++; if (bc !== 33) begin n_fail++; $display("FAIL mul_busy_cycles got %0d want 33", bc); end
        n_tests++; if (r !== 32'd70) begin n_fail++; $display("FAIL mul_ry got %h want 46", r); end
        n_tests++; if (c !== 5'd3) begin n_fail++; $display("FAIL mul_rc got %0d want 3", c); end
        n_tests++; if (le !== 1'b1) begin n_fail++; $display("FAIL mul_le got %0b want 1", le); end
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_after got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse got %0b want 0", done); end
        n_tests++; if (load_enable !== 1'b0) begin n_fail++; $display("FAIL mul_le_pulse got %0b want 0", load_enable); end
        n_tests++; if (ry !== 32'd70) begin n_fail++; $display("FAIL mul_ry_hold got %h want 46", ry); end
    endtask

    task automatic test_mul_full;
        int lat, bc; logic [31:0] r; logic [4:0] c; logic le;
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, lat, bc, r, c, le);
        n_tests++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_ff got %h want fffffffe", r); end
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, bc, r, c, le);
        n_tests++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_ff got %h want 00000001", r); end
        run_op(OP_MULHU, 32'h1234_5678, 32'h0001_0000, 5'd0, lat, bc, r, c, le);
        n_tests++; if (r !== 32'h0000_1234) begin n_fail++; $display("FAIL mulhu_shift got %h want 00001234", r); end
        n_tests++; if (c !== 5'd0) begin n_fail++; $display("FAIL rc_zero got %0d want 0", c); end
        n_tests++; if (le !== 1'b1) begin n_fail++; $display("FAIL rc_zero_le got %0b want 1", le); end
    endtask

    task automatic test_div;
        int lat, bc; logic [31:0] r; logic [4:0] c; logic le;
        run_op(OP_DIVU, 32'd10, 32'd7, 5'd4, lat, bc, r, c, le);
        n_tests++; if (r !== 32'd1) begin n_fail++; $display("FAIL divu_10_7 got %h want 1", r); end
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got %0d want 33", lat); end
        run_op(OP_REMU, 32'd10, 32'd7, 5'd5, lat, bc, r, c, le);
        n_tests++; if (r !== 32'd3) begin n_fail++; $display("FAIL remu_10_7 got %h want 3", r); end
        run_op(OP_DIVU, 32'd4, 32'd10, 5'd6, lat, bc, r, c, le);
        n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL divu_4_10 got %h want 0", r); end
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'h0001_0000, 5'd7, lat, bc, r, c, le);
        n_tests++; if (r !== 32'h0000_FFFF) begin n_fail++; $display("FAIL remu_big got %h want 0000ffff", r); end
    endtask

    task automatic test_zero;
        int lat, bc; logic [31:0] r; logic [4:0] c; logic le;
        run_op(OP_DIVU, 32'd7, 32'd0, 5'd8, lat, bc, r, c, le);
        n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0 got %h want ffffffff", r); end
        n_tests++; if (lat !== ZERO_LAT) begin n_fail++; $display("FAIL divu_by0_latency got %0d want %0d", lat, ZERO_LAT); end
        n_tests++; if (c !== 5'd8) begin n_fail++; $display("FAIL divu_by0_rc got %0d want 8", c); end
        run_op(OP_REMU, 32'd7, 32'd0, 5'd9, lat, bc, r, c, le);
        n_tests++; if (r !== 32'd7) begin n_fail++; $display("FAIL remu_by0 got %h want 7", r); end
        n_tests++; if (lat !== ZERO_LAT) begin n_fail++; $display("FAIL remu_by0_latency got %0d want %0d", lat, ZERO_LAT); end
        run_op(OP_MULHU, 32'd0, 32'hFFFF_FFFF, 5'd10, lat, bc, r, c, le);
        n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL mul_a0 got %h want 0", r); end
        n_tests++; if (lat !== ZERO_LAT) begin n_fail++; $display("FAIL mul_a0_latency got %0d want %0d", lat, ZERO_LAT); end
    endtask

    task automatic test_ignore_start;
        int ndone, late_busy; logic [31:0] r; logic [4:0] c;
        ndone = 0; late_busy = 0; r = '0; c = '0;
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd5; rc_in = 5'd11;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            if (done) begin ndone++; r = ry; c = rc; end
            if (i > 34 && busy) late_busy++;
            start = (i == 5) || (i == 20) || done;
            op = OP_DIVU; a = 32'd100; b = 32'd100; rc_in = 5'd12;
            @(negedge clk);
        end
        start = 1'b0;
        n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        n_tests++; if (r !== 32'd15) begin n_fail++; $display("FAIL ignore_ry got %h want f", r); end
        n_tests++; if (c !== 5'd11) begin n_fail++; $display("FAIL ignore_rc got %0d want 11", c); end
        n_tests++; if (late_busy !== 0) begin n_fail++; $display("FAIL ignore_no_restart got %0d busy cycles want 0", late_busy); end
    endtask

    task automatic test_back_to_back;
        int lat, bc; logic [31:0] r; logic [4:0] c; logic le;
        run_op(OP_MULHU, 32'h8000_0000, 32'd4, 5'd13, lat, bc, r, c, le);
        n_tests++; if (r !== 32'd2) begin n_fail++; $display("FAIL b2b_mulhu got %h want 2", r); end
        run_op(OP_REMU, 32'd100, 32'd7, 5'd14, lat, bc, r, c, le);
        n_tests++; if (r !== 32'd2) begin n_fail++; $display("FAIL b2b_remu got %h want 2", r); end
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", lat); end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd15, lat, bc, r, c, le);
        n_tests++; if (r !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL b2b_divu got %h want 0fffffff", r); end
        n_tests++; if (c !== 5'd15) begin n_fail++; $display("FAIL b2b_rc got %0d want 15", c); end
    endtask

    task automatic test_reset_mid;
        int ndone, lat, bc; logic [31:0] r; logic [4:0] c; logic le;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3; rc_in = 5'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        n_tests++; if (ry !== 32'd0) begin n_fail++; $display("FAIL rstmid_ry got %h want 0", ry); end
        n_tests++; if (rc !== 5'd0) begin n_fail++; $display("FAIL rstmid_rc got %0d want 0", rc); end
        n_tests++; if (load_enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_le got %0b want 0", load_enable); end
        for (int i = 0; i < 40; i++) begin
            if (done || load_enable) ndone++;
            @(negedge clk);
        end
        n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
        run_op(OP_DIVU, 32'd10, 32'd4, 5'd16, lat, bc, r, c, le);
        n_tests++; if (r !== 32'd2) begin n_fail++; $display("FAIL rstmid_divu got %h want 2", r); end
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL rstmid_latency got %0d want 33", lat); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_full();
        test_div();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
